fifo_bist_read_checker: RTL
===========================

Name: fifo_bist_read_checker

Overview:
Read-side response analyzer for the FIFO memory BIST. After the BIST write pass fills the array with a known pattern, this block sweeps every address on the read port and regenerates the expected word for each one. It compares each returned word against the expected value and reports pass/fail, the error count and the first failing address. It sits beside fifo_mem and drives the read port while BIST is active, clocked by WCLK.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH

Ports:
WCLK  input  1  single BIST clock (rising edge)
RST  input  1  synchronous, active-high reset
START  input  1  one-cycle start pulse; sampled only in IDLE or DONE
PASS_SEL  input  1  pattern select: 0 = true pattern, 1 = inverted pattern
R_INC  output  1  memory read enable, one address per cycle
B_RADDR  output  ADDR_WIDTH  read address presented to the memory
RDATA  input  DATA_WIDTH  memory read data, valid 1 cycle after R_INC
EXPECTED  output  DATA_WIDTH  expected word aligned with the RDATA under compare
BUSY  output  1  high in READ and DRAIN
DONE  output  1  high in DONE; results valid
PASSFAIL  output  1  1 = all words matched; valid when DONE=1
ERR_CNT  output  ADDR_WIDTH+1  number of mismatching addresses
FAIL_ADDR  output  ADDR_WIDTH  address of the first mismatch; 0 if none

Behaviour:
- Reset values (RST=1 at an edge): state IDLE; R_INC=0, B_RADDR=0, EXPECTED=0, BUSY=0, DONE=0, PASSFAIL=0, ERR_CNT=0, FAIL_ADDR=0. RST has priority over START.
- Reset applied mid-sweep aborts the sweep. All results are discarded. A new START is required.
- Pattern: exp(a) = address a replicated to fill DATA_WIDTH (LSB-aligned, truncated at MSB), XORed with all-ones when PASS_SEL=1.
  - Example, 8/4: a=3 gives 8'h33, or 8'hCC when PASS_SEL=1.
  - PASS_SEL is latched at START and held for the whole sweep.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: START=1 goes to READ. Address counter, ERR_CNT and FAIL_ADDR clear. PASS_SEL is latched.
  - READ: R_INC=1 and B_RADDR=counter. The counter increments every cycle. After address 2**ADDR_WIDTH-1 is issued, go to DRAIN. There is no wrap; each address is read exactly once.
  - DRAIN: R_INC=0. The final word is compared. Go to DONE.
  - DONE: DONE=1 and PASSFAIL=(ERR_CNT==0). Outputs are held until START, which re-enters READ with the same clearing as IDLE. DONE deasserts on that same edge.
- Compare pipeline:
  - A valid/address register tracks each issued read. A read issued in cycle n is compared using RDATA in cycle n+1.
  - EXPECTED shows exp(addr of the read issued in cycle n) during cycle n+1. It holds its last value when no compare is active.
  - On mismatch, ERR_CNT increments. FAIL_ADDR is captured only when ERR_CNT==0 before the increment.
  - ERR_CNT max is 2**ADDR_WIDTH, which fits its width, so no saturation is needed.
- Latency: START sampled at edge t.
  - READ spans cycles t+1 .. t+2**ADDR_WIDTH.
  - DRAIN is one cycle.
  - DONE=1 from cycle t+2**ADDR_WIDTH+2 (t+18 for depth 16).
  - BUSY is high for 2**ADDR_WIDTH+1 cycles.
- START while BUSY=1 is ignored: no restart and no effect on the counters.
- A START held high across DONE restarts once per entry to DONE.

Test Plan:
1. Memory model returns exp(a), PASS_SEL=0, START pulse -> R_INC high 16 cycles covering B_RADDR 0..F. DONE at START+18, PASSFAIL=1, ERR_CNT=0, FAIL_ADDR=0.
2. PASS_SEL=1 latched, then toggled to 0 mid-sweep; model returns inverted data -> addr 3 compared against 8'hCC, PASSFAIL=1, ERR_CNT=0.
3. Model corrupts addr 5 (returns 8'h54 instead of 8'h55) -> ERR_CNT=1, FAIL_ADDR=5, PASSFAIL=0. Repeat with addr F to check the DRAIN-cycle compare.
4. Model corrupts addrs 3 and 9; second START from DONE with a clean model -> first run ERR_CNT=2, FAIL_ADDR=3. Second run clears to ERR_CNT=0, PASSFAIL=1.
5. Model returns 8'h00 everywhere, PASS_SEL=0 -> only addr 0 matches: ERR_CNT=15, FAIL_ADDR=1, PASSFAIL=0.
6. RST=1 while B_RADDR=7, plus START pulses during READ -> all outputs at reset values next cycle. Extra STARTs cause no restart. A fresh START completes a normal 18-cycle run.

Source files
------------

// File: rtl/fifo_bist_read_checker.sv
// Read-side response analyzer for the FIFO memory BIST: sweeps every address once,
// regenerates the address-replicated pattern and tallies mismatches against RDATA.
module fifo_bist_read_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  PASS_SEL,
  output logic                  R_INC,
  output logic [ADDR_WIDTH-1:0] B_RADDR,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic [DATA_WIDTH-1:0] EXPECTED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASSFAIL,
  output logic [ADDR_WIDTH:0]   ERR_CNT,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_reg;
  logic                  pass_sel_reg;
  logic                  r_inc_reg;
  logic [ADDR_WIDTH-1:0] b_raddr_reg;
  logic                  cmp_valid_reg;
  logic [ADDR_WIDTH-1:0] cmp_addr_reg;
  logic [DATA_WIDTH-1:0] expected_reg;
  logic [ADDR_WIDTH:0]   err_cnt_reg;
  logic [ADDR_WIDTH-1:0] fail_addr_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  passfail_reg;

  logic [DATA_WIDTH-1:0] pattern_base;
  logic                  mismatch;
  logic [ADDR_WIDTH:0]   err_cnt_next;

  // Address replicated across the word, LSB-aligned; upper copies truncate at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_pattern
      assign pattern_base[gi] = b_raddr_reg[gi % ADDR_WIDTH];
    end
  endgenerate

  assign mismatch     = cmp_valid_reg && (RDATA != expected_reg);
  assign err_cnt_next = err_cnt_reg + {{ADDR_WIDTH{1'b0}}, mismatch};

  always_ff @(posedge WCLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      pass_sel_reg  <= 1'b0;
      r_inc_reg     <= 1'b0;
      b_raddr_reg   <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_addr_reg  <= '0;
      expected_reg  <= '0;
      err_cnt_reg   <= '0;
      fail_addr_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      passfail_reg  <= 1'b0;
    end else begin
      // Compare stage: a read issued this cycle is checked against RDATA next cycle.
      cmp_valid_reg <= r_inc_reg;
      if (r_inc_reg) begin
        cmp_addr_reg <= b_raddr_reg;
        expected_reg <= pattern_base ^ {DATA_WIDTH{pass_sel_reg}};
      end
      if (mismatch) begin
        err_cnt_reg <= err_cnt_next;
        if (err_cnt_reg == '0) begin
          fail_addr_reg <= cmp_addr_reg;
        end
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_reg     <= ST_READ;
            pass_sel_reg  <= PASS_SEL;
            r_inc_reg     <= 1'b1;
            b_raddr_reg   <= '0;
            err_cnt_reg   <= '0;
            fail_addr_reg <= '0;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            passfail_reg  <= 1'b0;
          end
        end
        ST_READ: begin
          if (b_raddr_reg == LAST_ADDR) begin
            state_reg <= ST_DRAIN;
            r_inc_reg <= 1'b0;
          end else begin
            b_raddr_reg <= b_raddr_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last word is compared on this edge, so use the post-compare count.
          state_reg    <= ST_DONE;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          passfail_reg <= (err_cnt_next == '0);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign R_INC     = r_inc_reg;
  assign B_RADDR   = b_raddr_reg;
  assign EXPECTED  = expected_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign PASSFAIL  = passfail_reg;
  assign ERR_CNT   = err_cnt_reg;
  assign FAIL_ADDR = fail_addr_reg;

endmodule
